// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard-unit controls, redirect target, imem lookup and IF/ID outputs.
// The fetch stage connects through the slave modport; its driver uses master.
interface fetch_stage_if;
   logic        pc_enable;
   logic        IF_ID_enable;
   logic        IF_ID_flush;
   logic        is_taken;
   logic [31:0] alu_data;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc_F;
   logic [31:0] instr_D;
   logic [31:0] pc_D;
   logic [31:0] pc4_D;
   logic        valid_D;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   modport slave (
      input  pc_enable, IF_ID_enable, IF_ID_flush, is_taken, alu_data, imem_rdata,
      output imem_addr, pc_F, instr_D, pc_D, pc4_D, valid_D, stall_cnt, flush_cnt
   );

   modport master (
      output pc_enable, IF_ID_enable, IF_ID_flush, is_taken, alu_data, imem_rdata,
      input  imem_addr, pc_F, instr_D, pc_D, pc4_D, valid_D, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch front end: program counter, BOOT/RUN sequencing and IF/ID register.
// Define FETCH_PERF_CNT_EN to build the stall/flush performance counters; otherwise both read 0.
module fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
   parameter int unsigned BOOT_CYCLES = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_stage_if.slave bus
);
   typedef enum logic {BOOT, RUN} state_e;

   localparam logic [3:0] BOOT_CNT_INIT = 4'(BOOT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  boot_cnt_q, boot_cnt_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_pc4_q, if_pc4_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      pc_d       = pc_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      if_pc4_d   = if_pc4_q;
      if_valid_d = if_valid_q;

      if (state_q == BOOT) begin
         // imem is still settling: keep the PC and feed bubbles, whatever the hazard unit says.
         if_instr_d = NOP_INSTR;
         if_pc_d    = '0;
         if_pc4_d   = '0;
         if_valid_d = 1'b0;
         if (boot_cnt_q == 4'd0) begin
            state_d = RUN;
         end else begin
            boot_cnt_d = boot_cnt_q - 4'd1;
         end
      end else begin
         if (bus.is_taken) begin
            pc_d = {bus.alu_data[31:2], 2'b00};
         end else if (bus.pc_enable) begin
            pc_d = pc_plus4;
         end

         if (bus.IF_ID_flush) begin
            if_instr_d = NOP_INSTR;
            if_pc_d    = '0;
            if_pc4_d   = '0;
            if_valid_d = 1'b0;
         end else if (bus.IF_ID_enable) begin
            if_instr_d = bus.imem_rdata;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_plus4;
            if_valid_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         boot_cnt_q <= BOOT_CNT_INIT;
         pc_q       <= RESET_PC;
         if_instr_q <= NOP_INSTR;
         if_pc_q    <= '0;
         if_pc4_q   <= '0;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         pc_q       <= pc_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
         if_pc4_q   <= if_pc4_d;
         if_valid_q <= if_valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Counters only count in RUN and stick at all-ones instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q == RUN) begin
         if (!bus.pc_enable && !bus.is_taken && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
         end
         if (bus.IF_ID_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.stall_cnt = '0;
   assign bus.flush_cnt = '0;
`endif

   assign bus.imem_addr = pc_q;
   assign bus.pc_F      = pc_q;
   assign bus.instr_D   = if_instr_q;
   assign bus.pc_D      = if_pc_q;
   assign bus.pc4_D     = if_pc4_q;
   assign bus.valid_D   = if_valid_q;
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the 5-stage RV32I pipeline. Holds the program counter and the IF/ID pipeline register, drives the combinational instruction-memory lookup, and produces `instr_D`/`pc_D` for decode and the hazard detection unit. It consumes the `pc_enable`, `IF_ID_enable`, `IF_ID_flush` and `is_taken` controls issued by the hazard detection unit, so it is the receiving end of that control interface.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`)
- `BOOT_CYCLES`, 2, cycles after reset before fetching starts (imem settle); legal range 1..15

Ports:
- `clk` input 1: single clock, all state updates on the rising edge
- `rst` input 1: reset, synchronous, active-high
- `pc_enable` input 1: 1 = advance PC; 0 = hold PC
- `IF_ID_enable` input 1: 1 = load the IF/ID register; 0 = hold it
- `IF_ID_flush` input 1: 1 = load a bubble into IF/ID
- `is_taken` input 1: redirect request from EX (branch taken, jal, jalr)
- `alu_data` input 32: redirect target
- `imem_addr` output 32: fetch address, equal to `pc_F` (combinational)
- `imem_rdata` input 32: instruction at `imem_addr`, same cycle
- `pc_F` output 32: current fetch PC
- `instr_D` output 32: IF/ID instruction
- `pc_D` output 32: IF/ID PC
- `pc4_D` output 32: IF/ID PC+4
- `valid_D` output 1: IF/ID holds a real instruction
- `stall_cnt` output 32: fetch stall cycles (see Configuration)
- `flush_cnt` output 32: IF/ID flush cycles (see Configuration)

## Operation
- FSM with two states, BOOT and RUN. Reset enters BOOT and loads the boot counter with `BOOT_CYCLES`-1.
  - BOOT: PC holds; IF/ID loads a bubble every cycle. All control inputs are ignored, including `is_taken`. The counter decrements each cycle; at 0 the FSM moves to RUN.
  - RUN: the FSM stays in RUN until `rst`.
- PC update in RUN, in priority order:
  1. `is_taken`: `pc_F` <= {`alu_data`[31:2], 2'b00}. This ignores `pc_enable`.
  2. `pc_enable`: `pc_F` <= `pc_F`+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
  3. Otherwise `pc_F` holds.
- IF/ID update in RUN, in priority order:
  1. `IF_ID_flush`: `instr_D`=`NOP_INSTR`, `pc_D`=0, `pc4_D`=0, `valid_D`=0. Flush wins over `IF_ID_enable`=0.
  2. `IF_ID_enable`: `instr_D`=`imem_rdata`, `pc_D`=`pc_F`, `pc4_D`=`pc_F`+4 (wraps), `valid_D`=1.
  3. Otherwise all four IF/ID outputs hold.
- `is_taken` with `IF_ID_flush`=0 is legal. The instruction fetched that cycle is then latched normally; discarding it is the hazard unit's responsibility.
- Reset values:
  - `pc_F`=`RESET_PC`
  - `instr_D`=`NOP_INSTR`, `pc_D`=0, `pc4_D`=0, `valid_D`=0
  - `stall_cnt`=0, `flush_cnt`=0
- Reset asserted mid-operation takes effect at the next edge regardless of all other inputs. The FSM re-enters BOOT.

## Timing
- Fetch-to-decode latency is 1 cycle. `imem_rdata` sampled at edge N appears on `instr_D` after edge N.
- Redirect: `is_taken` high in cycle N gives `pc_F`=target after edge N. The target instruction is on `instr_D` after edge N+1, provided `IF_ID_enable` is high in cycle N+1.
- First fetch: `pc_F`=`RESET_PC` throughout BOOT. The first valid `instr_D` appears `BOOT_CYCLES`+1 edges after the reset-release edge.
- `imem_addr` has no register stage. The memory must return data combinationally within the cycle.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `stall_cnt` increments in RUN in every cycle where `pc_enable`=0 and `is_taken`=0.
  - `flush_cnt` increments in RUN in every cycle where `IF_ID_flush`=1.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by `rst`.
- `FETCH_PERF_CNT_EN` undefined: both ports remain present and are tied to 0, and no counter flops are synthesized.

## Test plan
- Reset with `BOOT_CYCLES`=2 and `RESET_PC`=0, then release with all enables high and imem returning addr|0xA000 → `valid_D` stays 0 for 2 cycles; then `instr_D`=0xA000, 0xA004, 0xA008 with `pc4_D`=`pc_D`+4.
- Hold `pc_enable`=0 and `IF_ID_enable`=0 for 3 cycles at `pc_F`=0x40 → `pc_F` and `instr_D` frozen; with the macro defined, `stall_cnt` rises by exactly 3.
- `is_taken`=1, `alu_data`=0x203, `IF_ID_flush`=1 in the same cycle → next cycle `pc_F`=0x200, `instr_D`=0x00000013, `valid_D`=0; the cycle after, `pc_D`=0x200.
- `IF_ID_flush`=1 with `IF_ID_enable`=0 → bubble loaded (flush wins); `flush_cnt`+1.
- `pc_F`=0xFFFF_FFFC with `pc_enable`=1 → next `pc_F`=0; `pc4_D` for that fetch=0.
- Assert `rst` for one cycle mid-run at `pc_F`=0x80 → `pc_F`=0, `valid_D`=0, counters 0, BOOT re-entered; `is_taken` raised during BOOT is ignored.
